// File: rtl/tdp_ram36k_port_arbiter.sv
// Round-robin arbiter sharing port A of a 36-bit x 1024 TDP_RAM36K among NUM_REQ requesters,
// with an optional clear sequencer that zeroes the memory after reset or on request.
module tdp_ram36k_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CLEAR_ON_RESET = 1,
  parameter int WORDS          = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  output logic [NUM_REQ-1:0]    REQ_READY,
  input  logic [NUM_REQ-1:0]    REQ_WE,
  input  logic [10*NUM_REQ-1:0] REQ_ADDR,
  input  logic [4*NUM_REQ-1:0]  REQ_BE,
  input  logic [36*NUM_REQ-1:0] REQ_WDATA,
  input  logic                  CLEAR_REQ,
  output logic                  BUSY,
  output logic                  RSP_VALID,
  output logic [2:0]            RSP_ID,
  output logic [35:0]           RSP_DATA,
  output logic                  WEN_A,
  output logic                  REN_A,
  output logic [3:0]            BE_A,
  output logic [14:0]           ADDR_A,
  output logic [31:0]           WDATA_A,
  output logic [3:0]            WPARITY_A,
  input  logic [31:0]           RDATA_A,
  input  logic [3:0]            RPARITY_A
);

  localparam logic [0:0] ST_CLEAR  = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [9:0] LAST_WORD = 10'(WORDS - 1);
  localparam logic [2:0] LAST_REQ  = 3'(NUM_REQ - 1);

  logic [0:0]         state_q, state_d;
  logic [9:0]         cnt_q, cnt_d;
  logic [2:0]         last_q, last_d;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         gidx;
  logic               found;
  logic               run;
  logic               hs;

  logic               sel_we;
  logic [9:0]         sel_addr;
  logic [3:0]         sel_be;
  logic [35:0]        sel_wd;

  logic               wen_q, wen_d;
  logic               ren_q, ren_d;
  logic [3:0]         be_q, be_d;
  logic [9:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wpar_q, wpar_d;

  logic               vld_p0, vld_p1;
  logic [2:0]         id_p0, id_p1;

  // Two passes: indices above last_q first, then wrap around to 0..last_q.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && REQ_VALID[i] && (i > int'(last_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gidx     = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && REQ_VALID[i] && (i <= int'(last_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gidx     = 3'(i);
      end
    end
  end

  assign run       = (state_q == ST_RUN) && !RESET;
  assign REQ_READY = run ? grant : '0;
  assign hs        = run && (|REQ_VALID);
  assign BUSY      = (state_q == ST_CLEAR);

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_be   = '0;
    sel_wd   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we   = REQ_WE[i];
        sel_addr = REQ_ADDR[10*i +: 10];
        sel_be   = REQ_BE[4*i +: 4];
        sel_wd   = REQ_WDATA[36*i +: 36];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 10'd1;
      if (cnt_q == LAST_WORD) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      if (hs) last_d = gidx;
      if (CLEAR_REQ) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end
  end

  // Address/byte-enable/data hold when idle; only the strobes drop.
  always_comb begin
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wpar_d  = wpar_q;
    if (state_q == ST_CLEAR) begin
      wen_d   = 1'b1;
      be_d    = 4'hF;
      addr_d  = cnt_q;
      wdata_d = '0;
      wpar_d  = '0;
    end else if (hs) begin
      addr_d = sel_addr;
      if (sel_we) begin
        wen_d   = 1'b1;
        be_d    = sel_be;
        wdata_d = sel_wd[31:0];
        wpar_d  = sel_wd[35:32];
      end else begin
        ren_d = 1'b1;
        be_d  = 4'h0;
      end
    end
  end

  // p0: read handshake registered alongside the RAM strobes; p1: RAM data is on RDATA_A.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      last_q  <= LAST_REQ;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wpar_q  <= '0;
      vld_p0  <= 1'b0;
      id_p0   <= '0;
      vld_p1  <= 1'b0;
      id_p1   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wpar_q  <= wpar_d;
      vld_p0  <= hs && !sel_we;
      id_p0   <= gidx;
      vld_p1  <= vld_p0;
      id_p1   <= id_p0;
    end
  end

  assign WEN_A     = wen_q;
  assign REN_A     = ren_q;
  assign BE_A      = be_q;
  assign ADDR_A    = {addr_q, 5'b0};
  assign WDATA_A   = wdata_q;
  assign WPARITY_A = wpar_q;
  assign RSP_VALID = vld_p1;
  assign RSP_ID    = id_p1;
  assign RSP_DATA  = {RPARITY_A, RDATA_A};

endmodule
